// File: rtl/memory_arbiter.sv
// Two-port (fetch/data) arbiter onto one single-ported RAM: data first, with a
// bounded data streak so fetches cannot starve, plus a per-access timeout watchdog.
module memory_arbiter #(
   parameter int          MAX_D_STREAK   = 4,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_WORD       = 32'hBAD1BAD1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic        ram_ready,
   output logic        timeout
);

   localparam int SW = $clog2(MAX_D_STREAK + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
   localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INST = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t         state_reg, state_next;
   logic [SW-1:0]  streak_reg, streak_next;
   logic [TW-1:0]  tcnt_reg, tcnt_next;
   logic [31:0]    addr_reg, addr_next;
   logic [31:0]    store_reg, store_next;
   logic           op_w_reg, op_w_next;

   logic           dreq;
   logic           done;
   logic [31:0]    result;

   assign dreq   = dREN | dWEN;
   assign result = ram_ready ? ramload : ERR_WORD;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg  <= IDLE;
         streak_reg <= '0;
         tcnt_reg   <= '0;
         addr_reg   <= '0;
         store_reg  <= '0;
         op_w_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         streak_reg <= streak_next;
         tcnt_reg   <= tcnt_next;
         addr_reg   <= addr_next;
         store_reg  <= store_next;
         op_w_reg   <= op_w_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      streak_next = streak_reg;
      tcnt_next   = tcnt_reg;
      addr_next   = addr_reg;
      store_next  = store_reg;
      op_w_next   = op_w_reg;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;
      iwait       = iREN;
      dwait       = dreq;
      iload       = '0;
      dload       = '0;
      timeout     = 1'b0;
      // A reset cycle must never report a completion or a watchdog pulse.
      done        = !RST && (ram_ready || (tcnt_reg == TCNT_LAST));

      case (state_reg)
         IDLE: begin
            tcnt_next = '0;
            if (dreq && !(iREN && streak_reg == STREAK_MAX)) begin
               state_next = DATA;
               addr_next  = daddr;
               store_next = dstore;
               op_w_next  = dWEN;
               if (!iREN)
                  streak_next = '0;
               else if (streak_reg != STREAK_MAX)
                  streak_next = streak_reg + 1'b1;
            end else if (iREN) begin
               state_next  = INST;
               addr_next   = iaddr;
               store_next  = '0;
               op_w_next   = 1'b0;
               streak_next = '0;
            end
         end

         INST, DATA: begin
            ramREN   = !op_w_reg;
            ramWEN   = op_w_reg;
            ramaddr  = addr_reg;
            ramstore = store_reg;
            if (done) begin
               state_next = IDLE;
               tcnt_next  = '0;
               timeout    = !ram_ready;
               // A withdrawn request still finishes on the RAM; its result is dropped.
               if (state_reg == INST) begin
                  iwait = 1'b0;
                  iload = iREN ? result : '0;
               end else begin
                  dwait = 1'b0;
                  dload = (dREN && !op_w_reg) ? result : '0;
               end
            end else begin
               tcnt_next = tcnt_reg + 1'b1;
            end
         end

         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: per-port expected-result queues filled at issue
// time, a negedge monitor that pops on every completion, and a bench-side RAM model.
module tb_memory_arbiter;

   localparam logic [31:0] ERR = 32'hBAD1BAD1;
   localparam int BUDGET = 300;

   logic        clk = 1'b0;
   logic        RST = 1'b1;
   logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
   logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
   logic        iwait, dwait, ramREN, ramWEN, timeout;
   logic [31:0] iload, dload, ramaddr, ramstore;
   logic [31:0] ramload = '0;
   logic        ram_ready = 1'b0;

   typedef struct packed {
      logic        w;
      logic        to;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] wd;
   } exp_t;

   exp_t        i_q[$];
   exp_t        d_q[$];
   bit          ord_q[$];      // 0 = fetch completion, 1 = data completion
   logic [31:0] ref_mem[128];
   int          lat_fix = 2;   // RAM ack delay in cycles after strobe start; -1 = random
   int          checks = 0;
   int          passes = 0;

   memory_arbiter #(.MAX_D_STREAK(4), .TIMEOUT_CYCLES(8), .ERR_WORD(ERR)) dut (
      .CLK(clk), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ram_ready(ram_ready), .timeout(timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int idx);
      return (idx == 16) ? 32'h8C220004 : (32'hC0DE0000 | 32'(idx * 3));
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %h, required %h", name, act, req);
   endfunction

   function automatic void expire(input string name);
      checks++;
      $display("FAIL %s: no completion within %0d cycles", name, BUDGET);
   endfunction

   // RAM model: address bit 9 marks a region that never acknowledges.
   initial begin
      logic [31:0] mem[128];
      bit busy;
      int cnt, lat;
      busy = 0; cnt = 0; lat = 0;
      for (int k = 0; k < 128; k++) mem[k] = init_word(k);
      forever begin
         @(posedge clk);
         #1;
         if (ramREN || ramWEN) begin
            if (!busy) begin
               busy = 1;
               cnt  = 0;
               lat  = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
            end
            if (!ramaddr[9] && cnt == lat) begin
               ram_ready = 1'b1;
               ramload   = ramWEN ? $urandom : mem[ramaddr[8:2]];
               if (ramWEN) mem[ramaddr[8:2]] = ramstore;
            end else begin
               ram_ready = 1'b0;
               ramload   = $urandom;
            end
            cnt++;
         end else begin
            busy      = 0;
            ram_ready = ($urandom_range(0, 7) == 0);  // stray acks while idle
            ramload   = $urandom;
         end
      end
   end

   // Monitor: every completion the DUT presents is matched against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      bit   seen;
      bit   port;
      seen = 0;
      if (!RST) begin
         if (iREN && !iwait) begin
            seen = 1;
            port = 0;
            if (i_q.size() == 0) begin
               checks++;
               $display("FAIL i_unexpected: fetch completion with empty queue, addr %h", ramaddr);
            end else begin
               e = i_q.pop_front();
               chk("iload", iload, e.data);
               chk("i_ramaddr", ramaddr, e.addr);
               chk("i_ramREN", 32'(ramREN), 32'd1);
               chk("i_timeout", 32'(timeout), 32'(e.to));
            end
            if (ord_q.size() > 0) chk("grant_order", 32'(port), 32'(ord_q.pop_front()));
         end
         if ((dREN || dWEN) && !dwait) begin
            seen = 1;
            port = 1;
            if (d_q.size() == 0) begin
               checks++;
               $display("FAIL d_unexpected: data completion with empty queue, addr %h", ramaddr);
            end else begin
               e = d_q.pop_front();
               chk("dload", dload, e.data);
               chk("d_ramaddr", ramaddr, e.addr);
               chk("d_ramWEN", 32'(ramWEN), 32'(e.w));
               if (e.w) chk("d_ramstore", ramstore, e.wd);
               chk("d_timeout", 32'(timeout), 32'(e.to));
            end
            if (ord_q.size() > 0) chk("grant_order", 32'(port), 32'(ord_q.pop_front()));
         end
         if (timeout && !seen) begin
            checks++;
            $display("FAIL spurious_timeout: got 1, required 0");
         end
      end
   end

   task automatic i_issue(input logic [31:0] a);
      exp_t e;
      e.w = 0; e.to = a[9]; e.addr = a; e.wd = '0;
      e.data = a[9] ? ERR : ref_mem[a[8:2]];
      i_q.push_back(e);
      iREN = 1'b1; iaddr = a;
   endtask

   task automatic d_issue(input bit w, input logic [31:0] a, input logic [31:0] wd);
      exp_t e;
      e.w = w; e.to = a[9]; e.addr = a; e.wd = wd;
      if (w) begin
         e.data = '0;
         if (!a[9]) ref_mem[a[8:2]] = wd;
      end else begin
         e.data = a[9] ? ERR : ref_mem[a[8:2]];
      end
      d_q.push_back(e);
      dREN = w ? 1'($urandom_range(0, 1)) : 1'b1;
      dWEN = w; daddr = a; dstore = wd;
   endtask

   task automatic i_finish(output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (iwait && n < BUDGET);
      if (iwait) expire("i_budget");
      @(posedge clk); #1;
      iREN = 1'b0;
   endtask

   task automatic d_finish(output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (dwait && n < BUDGET);
      if (dwait) expire("d_budget");
      @(posedge clk); #1;
      dREN = 1'b0; dWEN = 1'b0;
   endtask

   task automatic i_access(input logic [31:0] a);
      int n;
      @(posedge clk); #1;
      i_issue(a);
      i_finish(n);
   endtask

   task automatic d_access(input bit w, input logic [31:0] a, input logic [31:0] wd, output int n);
      @(posedge clk); #1;
      d_issue(w, a, wd);
      d_finish(n);
   endtask

   initial begin
      #400000;
      $display("FAIL global_watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n1, n2;
      exp_t e_tmp;
      for (int k = 0; k < 128; k++) ref_mem[k] = init_word(k);

      // Reset held with both requests pending; data wins right after release.
      lat_fix = 2;
      repeat (2) @(posedge clk);
      #1;
      i_issue(32'h44);
      d_issue(1'b1, 32'h180, 32'h12345678);
      @(negedge clk);
      chk("rst_ramREN", 32'(ramREN), 32'd0);
      chk("rst_ramWEN", 32'(ramWEN), 32'd0);
      chk("rst_iwait", 32'(iwait), 32'd1);
      chk("rst_dwait", 32'(dwait), 32'd1);
      @(posedge clk); #1;
      RST = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_data_grant", 32'(ramWEN), 32'd1);
      chk("rst_grant_addr", ramaddr, 32'h180);
      fork
         d_finish(n1);
         i_finish(n2);
      join

      // Single fetch, ack two cycles after the strobe.
      i_access(32'h40);

      // Starvation guard: four data grants, then one fetch, repeating.
      lat_fix = 0;
      @(posedge clk); #1;
      for (int k = 0; k < 10; k++) begin
         e_tmp.w = 0; e_tmp.to = 0; e_tmp.wd = '0;
         if (k % 5 == 4) begin
            e_tmp.addr = 32'h44; e_tmp.data = ref_mem[17];
            i_q.push_back(e_tmp);
            ord_q.push_back(1'b0);
         end else begin
            e_tmp.addr = 32'h108; e_tmp.data = ref_mem[66];
            d_q.push_back(e_tmp);
            ord_q.push_back(1'b1);
         end
      end
      iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h108;
      n1 = 0;
      while (ord_q.size() > 0 && n1 < BUDGET) begin
         @(negedge clk); #1;
         n1++;
      end
      if (ord_q.size() > 0) expire("grant_order_budget");
      @(posedge clk); #1;
      iREN = 1'b0; dREN = 1'b0;

      // Write then read back.
      lat_fix = 1;
      d_access(1'b1, 32'h100, 32'hDEADBEEF, n1);
      d_access(1'b0, 32'h100, 32'h0, n1);

      // Watchdog: completes in the 8th DATA cycle, then back to idle.
      d_access(1'b0, 32'h380, 32'h0, n1);
      chk("timeout_latency", 32'(n1), 32'd9);
      @(negedge clk);
      chk("timeout_idle_strobe", 32'(ramREN | ramWEN), 32'd0);

      // Reset exactly in the cycle the watchdog would fire.
      @(posedge clk); #1;
      i_issue(32'h240);
      e_tmp = i_q.pop_back();
      repeat (8) @(negedge clk);
      @(posedge clk); #1;
      RST = 1'b1; iREN = 1'b0;
      @(negedge clk);
      chk("rst_no_timeout", 32'(timeout), 32'd0);
      @(posedge clk); #1;
      RST = 1'b0;
      @(negedge clk);
      chk("rst_abort_strobe", 32'(ramREN | ramWEN), 32'd0);
      chk("rst_abort_timeout", 32'(timeout), 32'd0);

      // Withdrawn read still runs to its RAM ack; dwait follows the inputs.
      lat_fix = 3;
      @(posedge clk); #1;
      d_issue(1'b0, 32'h104, 32'h0);
      e_tmp = d_q.pop_back();
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      dREN = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("withdraw_dwait", 32'(dwait), 32'd0);
         chk("withdraw_strobe", 32'(ramREN), 32'(k <= 2));
      end
      d_access(1'b0, 32'h104, 32'h0, n1);

      // Randomized concurrent traffic on both ports.
      lat_fix = -1;
      fork
         begin
            for (int k = 0; k < 40; k++) begin
               logic [31:0] a;
               repeat ($urandom_range(0, 2)) @(posedge clk);
               a = (32'($urandom_range(0, 63)) << 2) |
                   (($urandom_range(0, 7) == 0) ? 32'h200 : 32'h0);
               i_access(a);
            end
         end
         begin
            for (int k = 0; k < 40; k++) begin
               logic [31:0] a;
               int          n;
               repeat ($urandom_range(0, 2)) @(posedge clk);
               a = 32'h100 | (32'($urandom_range(0, 63)) << 2) |
                   (($urandom_range(0, 7) == 0) ? 32'h200 : 32'h0);
               d_access(1'($urandom_range(0, 1)), a, $urandom, n);
            end
         end
      join

      repeat (3) @(negedge clk);
      chk("i_q_drained", 32'(i_q.size()), 32'd0);
      chk("d_q_drained", 32'(d_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
